// File: rtl/ucca_reset_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl_pkg
// Shared definitions for the UCCA reset controller and its region checker:
//   - FSM state encoding (IDLE/HOLD/DRAIN, 2'b11 unused)
//   - cause bit positions inside violation_cause
//   - the reset handler address, used as the cleared value of violation_pc
//   - a helper that turns the checker outputs into a cause vector
// ---------------------------------------------------------------------------
package ucca_reset_ctrl_pkg;

  localparam int PC_W    = 16;
  localparam int CAUSE_W = 2;

  // Cause bit positions
  localparam int CAUSE_RET   = 0;  // return-integrity sub-check fired
  localparam int CAUSE_OTHER = 1;  // any other checker rule fired

  // Reset vector shared with the region checker
  localparam logic [PC_W-1:0] RESET_HANDLER = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Cause vector for a violation level plus its return qualifier.
  function automatic logic [CAUSE_W-1:0] cause_of(input logic viol, input logic ret);
    logic [CAUSE_W-1:0] c;
    c              = '0;
    c[CAUSE_RET]   = viol & ret;
    c[CAUSE_OTHER] = viol & ~ret;
    return c;
  endfunction

endpackage

// File: rtl/ucca_reset_ctrl_if.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl_if
// Bundles the violation inputs and the reset/status outputs of the UCCA
// reset controller.
//   master : drives ucca_reset, return_reset, pc, clr_status;
//            observes puc_req, busy and the forensic status.
//   slave  : the controller itself.
// Signals:
//   ucca_reset      violation level from the region checker
//   return_reset    high when the return-integrity sub-check fired
//   pc              current program counter
//   clr_status      single-cycle clear of sticky status and counter
//   puc_req         CPU reset request toward the core
//   busy            controller is handling a violation episode
//   violation_seen  sticky "a violation happened" flag
//   violation_pc    pc captured at the last violation
//   violation_cause cause of the last violation
//   violation_cnt   saturating number of captured violations
// ---------------------------------------------------------------------------
interface ucca_reset_ctrl_if
  import ucca_reset_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic               ucca_reset;
  logic               return_reset;
  logic [PC_W-1:0]    pc;
  logic               clr_status;
  logic               puc_req;
  logic               busy;
  logic               violation_seen;
  logic [PC_W-1:0]    violation_pc;
  logic [CAUSE_W-1:0] violation_cause;
  logic [CNT_W-1:0]   violation_cnt;

  modport master (
    output ucca_reset, return_reset, pc, clr_status,
    input  puc_req, busy, violation_seen, violation_pc, violation_cause, violation_cnt
  );

  modport slave (
    input  ucca_reset, return_reset, pc, clr_status,
    output puc_req, busy, violation_seen, violation_pc, violation_cause, violation_cnt
  );

endinterface

// File: rtl/ucca_reset_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl_sat_counter
// Saturating up-counter with synchronous clear. When clr and inc arrive in
// the same cycle the clear is applied first, so the result is 1.
// Ports:
//   clk            rising-edge clock
//   system_reset_n synchronous active-low reset
//   clr            clear to zero
//   inc            increment by one, holding at all-ones
//   count          registered count value
// ---------------------------------------------------------------------------
module ucca_reset_ctrl_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             system_reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end
    // Saturate: never wrap back to zero
    if (inc && (count_next != {WIDTH{1'b1}})) begin
      count_next = count_next + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!system_reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ucca_reset_ctrl.sv
// ---------------------------------------------------------------------------
// ucca_reset_ctrl
// Converts a violation level from the UCCA region checker into a clean,
// minimum-length CPU reset request for the openMSP430 core, and records
// forensic status (faulting pc, cause, sticky flag, saturating count).
// Ports:
//   clk            rising-edge clock
//   system_reset_n synchronous active-low reset
//   bus            ucca_reset_ctrl_if.slave (violation inputs, reset
//                  request, busy and status outputs)
// Parameters:
//   HOLD_CYCLES    minimum puc_req length per violation (1..255)
//   CNT_W          width of violation_cnt (must match the interface)
// ---------------------------------------------------------------------------
module ucca_reset_ctrl
  import ucca_reset_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              system_reset_n,
  ucca_reset_ctrl_if.slave  bus
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e              state_reg;
  state_e              state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [HOLD_W-1:0]   hold_cnt_next;
  logic                puc_req_reg;
  logic                puc_req_next;
  logic                busy_reg;
  logic                capture;
  logic                seen_reg;
  logic [PC_W-1:0]     vpc_reg;
  logic [CAUSE_W-1:0]  cause_reg;

  // -------------------------------------------------------------------------
  // FSM next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    puc_req_next  = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.ucca_reset) begin
          capture       = 1'b1;
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_LOAD;
          puc_req_next  = 1'b1;
        end
      end
      ST_HOLD: begin
        puc_req_next = 1'b1;
        if (hold_cnt_reg == '0) begin
          // Minimum hold done: keep requesting only if the violation is
          // still present, so a short violation yields exactly HOLD_CYCLES.
          state_next   = ST_DRAIN;
          puc_req_next = bus.ucca_reset;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      ST_DRAIN: begin
        // The request follows the violation level and lingers for one
        // extra cycle after the level is sampled low. Inside DRAIN the
        // registered request equals the previous ucca_reset sample.
        puc_req_next = bus.ucca_reset | puc_req_reg;
        if (!bus.ucca_reset) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!system_reset_n) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      puc_req_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      puc_req_reg  <= puc_req_next;
      busy_reg     <= (state_next != ST_IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Forensic status: a capture overrides a clear in the same cycle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!system_reset_n) begin
      seen_reg  <= 1'b0;
      vpc_reg   <= RESET_HANDLER;
      cause_reg <= '0;
    end else if (capture) begin
      seen_reg  <= 1'b1;
      vpc_reg   <= bus.pc;
      cause_reg <= cause_of(bus.ucca_reset, bus.return_reset);
    end else if (bus.clr_status) begin
      seen_reg  <= 1'b0;
      vpc_reg   <= RESET_HANDLER;
      cause_reg <= '0;
    end
  end

  ucca_reset_ctrl_sat_counter #(
    .WIDTH (CNT_W)
  ) u_viol_cnt (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .clr            (bus.clr_status),
    .inc            (capture),
    .count          (bus.violation_cnt)
  );

  assign bus.puc_req         = puc_req_reg;
  assign bus.busy            = busy_reg;
  assign bus.violation_seen  = seen_reg;
  assign bus.violation_pc    = vpc_reg;
  assign bus.violation_cause = cause_reg;

  // Elaboration sanity on the hold length
  always_ff @(posedge clk) begin
    hold_range_ok : assert (HOLD_CYCLES >= 1 && HOLD_CYCLES <= 255);
  end

endmodule

// File: tb/tb_ucca_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ucca_reset_ctrl
// Two controllers share one stimulus stream: A (HOLD_CYCLES=16, CNT_W=8)
// and B (HOLD_CYCLES=1, CNT_W=2). An episode-level reference model derives
// every output from the capture edge index and the ucca_reset history.
// ---------------------------------------------------------------------------
module tb_ucca_reset_ctrl;

  localparam int H_A = 16;
  localparam int W_A = 8;
  localparam int H_B = 1;
  localparam int W_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic system_reset_n;

  ucca_reset_ctrl_if #(.CNT_W(W_A)) bus_a ();
  ucca_reset_ctrl_if #(.CNT_W(W_B)) bus_b ();

  ucca_reset_ctrl #(.HOLD_CYCLES(H_A), .CNT_W(W_A)) dut_a (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .bus            (bus_a.slave)
  );

  ucca_reset_ctrl #(.HOLD_CYCLES(H_B), .CNT_W(W_B)) dut_b (
    .clk            (clk),
    .system_reset_n (system_reset_n),
    .bus            (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus copies read by the model
  logic        u_v, r_v, c_v;
  logic [15:0] p_v;

  // Reference model: one slot per DUT
  int          hold_of [2] = '{H_A, H_B};
  int          cmax    [2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
  bit          m_alive [2];
  longint      m_c     [2];
  bit          m_puc   [2];
  bit          m_busy  [2];
  bit          m_seen  [2];
  logic [15:0] m_pc    [2];
  logic [1:0]  m_cause [2];
  int          m_cnt   [2];
  longint      t = 0;
  bit          prev_u = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic u, input logic r, input logic [15:0] p, input logic c);
    u_v = u; r_v = r; p_v = p; c_v = c;
    bus_a.ucca_reset = u; bus_a.return_reset = r; bus_a.pc = p; bus_a.clr_status = c;
    bus_b.ucca_reset = u; bus_b.return_reset = r; bus_b.pc = p; bus_b.clr_status = c;
  endtask

  // Expected outputs after edge t, from the episode rules:
  //   capture edge c -> request for edges c..c+H-1 regardless of the input;
  //   afterwards the request is ucca(t) | ucca(t-1) (no look-back at c+H);
  //   the episode ends at the first edge >= c+H+1 that samples ucca low.
  task automatic model_edge();
    bit cap;
    for (int k = 0; k < 2; k++) begin
      if (!system_reset_n) begin
        m_alive[k] = 0; m_puc[k] = 0; m_busy[k] = 0;
        m_seen[k] = 0; m_pc[k] = 16'h0000; m_cause[k] = 2'b00; m_cnt[k] = 0;
      end else begin
        cap = !m_alive[k] && u_v;
        if (cap) begin
          m_alive[k] = 1; m_c[k] = t; m_puc[k] = 1; m_busy[k] = 1;
        end else if (m_alive[k]) begin
          if (t >= m_c[k] + hold_of[k] + 1 && !u_v) begin
            m_alive[k] = 0; m_busy[k] = 0; m_puc[k] = prev_u;
          end else begin
            m_busy[k] = 1;
            m_puc[k]  = (t < m_c[k] + hold_of[k]) || u_v ||
                        ((t > m_c[k] + hold_of[k]) && prev_u);
          end
        end else begin
          m_puc[k] = 0; m_busy[k] = 0;
        end
        if (cap) begin
          m_seen[k]  = 1;
          m_pc[k]    = p_v;
          m_cause[k] = r_v ? 2'b01 : 2'b10;
          m_cnt[k]   = c_v ? 1 : ((m_cnt[k] + 1 > cmax[k]) ? cmax[k] : m_cnt[k] + 1);
        end else if (c_v) begin
          m_seen[k] = 0; m_pc[k] = 16'h0000; m_cause[k] = 2'b00; m_cnt[k] = 0;
        end
      end
    end
    prev_u = u_v;
    t++;
  endtask

  task automatic compare_all();
    chk("a_puc",   32'(bus_a.puc_req),         32'(m_puc[0]));
    chk("a_busy",  32'(bus_a.busy),            32'(m_busy[0]));
    chk("a_seen",  32'(bus_a.violation_seen),  32'(m_seen[0]));
    chk("a_pc",    32'(bus_a.violation_pc),    32'(m_pc[0]));
    chk("a_cause", 32'(bus_a.violation_cause), 32'(m_cause[0]));
    chk("a_cnt",   32'(bus_a.violation_cnt),   32'(m_cnt[0]));
    chk("b_puc",   32'(bus_b.puc_req),         32'(m_puc[1]));
    chk("b_busy",  32'(bus_b.busy),            32'(m_busy[1]));
    chk("b_seen",  32'(bus_b.violation_seen),  32'(m_seen[1]));
    chk("b_pc",    32'(bus_b.violation_pc),    32'(m_pc[1]));
    chk("b_cause", 32'(bus_b.violation_cause), 32'(m_cause[1]));
    chk("b_cnt",   32'(bus_b.violation_cnt),   32'(m_cnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Hold ucca_reset high for hi cycles, then low until both DUTs are idle.
  // na/nb count the cycles each DUT drove puc_req high.
  task automatic episode(input int hi, input logic r, input logic [15:0] p,
                         input logic clr_first, output int na, output int nb);
    int guard;
    na = 0; nb = 0; guard = 0;
    for (int i = 0; i < hi; i++) begin
      drive(1'b1, r, p, (i == 0) ? clr_first : 1'b0);
      tick();
      na += int'(bus_a.puc_req);
      nb += int'(bus_b.puc_req);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    while ((bus_a.busy || bus_a.puc_req || bus_b.busy || bus_b.puc_req) && guard < 200) begin
      tick();
      na += int'(bus_a.puc_req);
      nb += int'(bus_b.puc_req);
      guard++;
    end
    chk("episode_timeout", 32'(guard >= 200), 32'(0));
    $display("episode hi=%0d ret=%0b pc=%h puc_a=%0d puc_b=%0d cnt_a=%0d cnt_b=%0d",
             hi, r, p, na, nb, bus_a.violation_cnt, bus_b.violation_cnt);
  endtask

  task automatic clear_status();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    $display("clear_status cnt_a=%0d cnt_b=%0d", bus_a.violation_cnt, bus_b.violation_cnt);
  endtask

  initial begin : stim
    int na, nb, run_left;
    logic run_u;

    // Reset: 3 cycles low, then release
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    system_reset_n = 1'b0;
    repeat (3) tick();
    system_reset_n = 1'b1;
    tick();
    chk("rst_puc",   32'(bus_a.puc_req),         32'(0));
    chk("rst_busy",  32'(bus_a.busy),            32'(0));
    chk("rst_seen",  32'(bus_a.violation_seen),  32'(0));
    chk("rst_pc",    32'(bus_a.violation_pc),    32'(16'h0000));
    chk("rst_cause", 32'(bus_a.violation_cause), 32'(0));
    chk("rst_cnt",   32'(bus_a.violation_cnt),   32'(0));
    $display("reset released");

    // Single return-integrity violation
    episode(1, 1'b1, 16'hE0A4, 1'b0, na, nb);
    chk("single_len_a",  32'(na), 32'(16));
    chk("single_len_b",  32'(nb), 32'(1));
    chk("single_pc",     32'(bus_a.violation_pc),    32'(16'hE0A4));
    chk("single_cause",  32'(bus_a.violation_cause), 32'(2'b01));
    chk("single_cnt",    32'(bus_a.violation_cnt),   32'(1));

    clear_status();
    chk("clr_cnt",  32'(bus_a.violation_cnt),  32'(0));
    chk("clr_seen", 32'(bus_a.violation_seen), 32'(0));

    // Long violation from another checker
    episode(40, 1'b0, 16'hC002, 1'b0, na, nb);
    chk("long_len_a", 32'(na), 32'(41));
    chk("long_len_b", 32'(nb), 32'(41));
    chk("long_cause", 32'(bus_a.violation_cause), 32'(2'b10));
    chk("long_cnt",   32'(bus_a.violation_cnt),   32'(1));

    // Saturation on the 2-bit counter
    clear_status();
    for (int i = 0; i < 5; i++) begin
      episode(1, 1'(i % 2), 16'h2000 + 16'(i), 1'b0, na, nb);
      chk("sat_cnt_b", 32'(bus_b.violation_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
      chk("sat_cnt_a", 32'(bus_a.violation_cnt), 32'(i + 1));
    end

    // Clear and capture in the same cycle
    clear_status();
    episode(1, 1'b1, 16'h3000, 1'b0, na, nb);
    episode(2, 1'b0, 16'h3004, 1'b0, na, nb);
    chk("pre_cnt",  32'(bus_a.violation_cnt),  32'(2));
    chk("pre_seen", 32'(bus_a.violation_seen), 32'(1));
    episode(1, 1'b0, 16'h0100, 1'b1, na, nb);
    chk("clrcap_cnt",  32'(bus_a.violation_cnt),  32'(1));
    chk("clrcap_seen", 32'(bus_a.violation_seen), 32'(1));
    chk("clrcap_pc",   32'(bus_a.violation_pc),   32'(16'h0100));

    // Reset asserted during the 5th HOLD cycle
    drive(1'b1, 1'b1, 16'h1234, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (4) tick();
    chk("midrst_pre_puc", 32'(bus_a.puc_req), 32'(1));
    system_reset_n = 1'b0;
    tick();
    chk("midrst_puc",  32'(bus_a.puc_req),       32'(0));
    chk("midrst_busy", 32'(bus_a.busy),          32'(0));
    chk("midrst_cnt",  32'(bus_a.violation_cnt), 32'(0));
    system_reset_n = 1'b1;
    tick();
    $display("mid-hold reset done");

    // Randomized runs of ucca_reset with occasional clears and resets
    run_left = 0;
    run_u    = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (run_left == 0) begin
        run_u    = ($urandom_range(0, 2) == 0);
        run_left = run_u ? $urandom_range(1, 30) : $urandom_range(1, 25);
        $display("random run cyc=%0d ucca=%0b len=%0d", cyc, run_u, run_left);
      end
      run_left--;
      system_reset_n = ($urandom_range(0, 299) != 0);
      drive(run_u, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
